// File: rtl/decode_pkg.sv
// Shared opcodes, enums and the decoded control bundle for the RV32 decode stage.
// The M-extension encoding is gated by DECODE_MUL_DIV_EN in insn_decoder.
package decode_pkg;

    localparam int ALU_CTRL_WIDTH = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_LUI   = 5'b01111;
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AUIPC = 5'b01110;

    typedef enum logic [2:0] {
        IMM_I  = 3'b000,
        IMM_S  = 3'b001,
        IMM_B  = 3'b010,
        IMM_J  = 3'b011,
        IMM_SH = 3'b100,
        IMM_U  = 3'b101
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef struct packed {
        result_src_e                result_src;
        logic                       branch;
        logic                       jal;
        logic                       jalr;
        logic                       mem_load;
        logic                       mem_store;
        logic [ALU_CTRL_WIDTH-1:0]  alu_control;
        logic                       alu_src;
        imm_src_e                   imm_src;
        logic                       reg_write;
        logic [4:0]                 rd;
        logic [4:0]                 rs1;
        logic [4:0]                 rs2;
        logic [2:0]                 funct3;
        logic                       uses_rs1;
        logic                       uses_rs2;
        logic                       md_op;
        logic                       illegal;
    } ctrl_t;

    // Only add and sra/sub-style ops have a funct7=0100000 encoding.
    function automatic logic r_alt_legal(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b101);
    endfunction

    // An illegal word must never write state, branch or touch memory.
    function automatic ctrl_t squash_effects(input ctrl_t c);
        ctrl_t s;
        s           = c;
        s.reg_write = 1'b0;
        s.mem_load  = 1'b0;
        s.mem_store = 1'b0;
        s.branch    = 1'b0;
        s.jal       = 1'b0;
        s.jalr      = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/decode_stage_insn_decoder.sv
// Combinational RV32I control decoder with illegal-instruction detection.
// Define DECODE_MUL_DIV_EN to accept funct7=0000001 R-type words as M-extension ops.
module insn_decoder
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_t      dec;
    logic       bad;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    always_comb begin
        dec        = '0;
        bad        = 1'b0;
        dec.rd     = instr_i[11:7];
        dec.rs1    = instr_i[19:15];
        dec.rs2    = instr_i[24:20];
        dec.funct3 = f3;

        case (opcode)
            OP_R: begin
                dec.uses_rs1    = 1'b1;
                dec.uses_rs2    = 1'b1;
                dec.reg_write   = 1'b1;
                dec.alu_control = {1'b0, f7[5], f3};
                if (f7 == F7_MULDIV) begin
`ifdef DECODE_MUL_DIV_EN
                    dec.alu_control = {2'b10, f3};
                    dec.md_op       = 1'b1;
`else
                    bad = 1'b1;
`endif
                end else if (f7 == F7_ALT) begin
                    bad = !r_alt_legal(f3);
                end else if (f7 != F7_BASE) begin
                    bad = 1'b1;
                end
            end
            // Loads and OP-IMM write rd like any other RV32 result-producing op.
            OP_LOAD: begin
                dec.result_src = RES_MEM;
                dec.mem_load   = 1'b1;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.uses_rs1   = 1'b1;
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OP_STORE: begin
                dec.mem_store = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = IMM_S;
                dec.uses_rs1  = 1'b1;
                dec.uses_rs2  = 1'b1;
                bad = (f3 > 3'b010);
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.imm_src  = IMM_B;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
                bad = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OP_IMM: begin
                dec.alu_control = {1'b0, f7[5] & (f3 == 3'b101), f3};
                dec.alu_src     = 1'b1;
                dec.reg_write   = 1'b1;
                dec.uses_rs1    = 1'b1;
                if (f3 == 3'b001) begin
                    dec.imm_src = IMM_SH;
                    bad = (f7 != F7_BASE);
                end else if (f3 == 3'b101) begin
                    dec.imm_src = IMM_SH;
                    bad = (f7 != F7_BASE) && (f7 != F7_ALT);
                end
            end
            OP_JALR: begin
                dec.jalr       = 1'b1;
                dec.result_src = RES_PC4;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.uses_rs1   = 1'b1;
                bad = (f3 != 3'b000);
            end
            OP_JAL: begin
                dec.jal        = 1'b1;
                dec.result_src = RES_PC4;
                dec.imm_src    = IMM_J;
                dec.reg_write  = 1'b1;
            end
            OP_LUI: begin
                dec.imm_src     = IMM_U;
                dec.alu_src     = 1'b1;
                dec.alu_control = ALU_LUI;
                dec.reg_write   = 1'b1;
            end
            OP_AUIPC: begin
                dec.imm_src     = IMM_U;
                dec.alu_control = ALU_AUIPC;
                dec.reg_write   = 1'b1;
            end
            OP_FENCE: begin
                bad = 1'b0;
            end
            default: begin
                bad = 1'b1;
            end
        endcase

        dec.illegal = bad || (instr_i[1:0] != 2'b11);
        if (dec.illegal) begin
            dec = squash_effects(dec);
        end
    end

    assign ctrl_o = dec;

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RV32 decode stage with a small in-order output FIFO.
// Optional M-extension decode is enabled by DECODE_MUL_DIV_EN (see insn_decoder).
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int BUF_DEPTH  = 2,
    parameter int ALU_CTRL_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output ctrl_t           out_ctrl,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr
);

    localparam int PTR_W = 1;
    localparam int CNT_W = 2;

    if (XLEN != 32) begin : g_bad_xlen
        $error("decode_stage: XLEN must be 32");
    end
    if ((BUF_DEPTH != 1) && (BUF_DEPTH != 2)) begin : g_bad_depth
        $error("decode_stage: BUF_DEPTH must be 1 or 2");
    end
    if (ALU_CTRL_W != ALU_CTRL_WIDTH) begin : g_bad_alu_w
        $error("decode_stage: ALU_CTRL_W must match the ctrl_t alu_control width");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;
    ctrl_t            dec_ctrl;

    ctrl_t            ctrl_mem_q  [BUF_DEPTH];
    logic [XLEN-1:0]  pc_mem_q    [BUF_DEPTH];
    logic [31:0]      instr_mem_q [BUF_DEPTH];

    insn_decoder u_insn_decoder (
        .instr_i (in_instr),
        .ctrl_o  (dec_ctrl)
    );

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // When full, a same-cycle pop frees the slot the new word will land in.
    assign in_ready  = (count_q < CNT_W'(BUF_DEPTH)) ||
                       ((count_q == CNT_W'(BUF_DEPTH)) && out_ready);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && in_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entries are reset so the head reads as all-zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                ctrl_mem_q[i]  <= '0;
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push) begin
            ctrl_mem_q[wr_ptr_q]  <= dec_ctrl;
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

    assign out_ctrl  = ctrl_mem_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_instr = instr_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: queue-based FIFO model plus a reference RV32 decoder.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int DEPTH = 2;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr  = '0;
    logic [31:0] in_pc     = '0;
    logic        in_ready;
    logic        out_valid;
    ctrl_t       out_ctrl;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    typedef struct packed {
        ctrl_t       c;
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    ent_t        model_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pc_ctr  = 32'h0000_1000;

    decode_stage #(.XLEN(32), .BUF_DEPTH(DEPTH), .ALU_CTRL_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_pc    (out_pc),
        .out_instr (out_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the instruction-set rules.
    function automatic ctrl_t ref_decode(input logic [31:0] w);
        ctrl_t      c;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ill;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        c = '0;
        ill = 1'b0;
        c.rd = w[11:7];
        c.rs1 = w[19:15];
        c.rs2 = w[24:20];
        c.funct3 = f3;
        case (op)
            7'b0110011: begin
                c.uses_rs1 = 1; c.uses_rs2 = 1; c.reg_write = 1;
                c.alu_control = {1'b0, f7[5], f3};
                if (f7 == 7'h00) ill = 0;
                else if (f7 == 7'h20) ill = !(f3 == 0 || f3 == 5);
                else if (f7 == 7'h01) begin
`ifdef DECODE_MUL_DIV_EN
                    c.alu_control = {2'b10, f3}; c.md_op = 1;
`else
                    ill = 1;
`endif
                end else ill = 1;
            end
            7'b0000011: begin
                c.result_src = RES_MEM; c.mem_load = 1; c.alu_src = 1;
                c.reg_write = 1; c.uses_rs1 = 1;
                ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
            end
            7'b0100011: begin
                c.mem_store = 1; c.alu_src = 1; c.imm_src = IMM_S;
                c.uses_rs1 = 1; c.uses_rs2 = 1;
                ill = (f3 > 2);
            end
            7'b1100011: begin
                c.branch = 1; c.imm_src = IMM_B; c.uses_rs1 = 1; c.uses_rs2 = 1;
                ill = (f3 == 2) || (f3 == 3);
            end
            7'b0010011: begin
                c.alu_control = {1'b0, (f7[5] && f3 == 5), f3};
                c.alu_src = 1; c.reg_write = 1; c.uses_rs1 = 1;
                c.imm_src = (f3 == 1 || f3 == 5) ? IMM_SH : IMM_I;
                if (f3 == 1) ill = (f7 != 0);
                if (f3 == 5) ill = !(f7 == 0 || f7 == 7'h20);
            end
            7'b1100111: begin
                c.jalr = 1; c.result_src = RES_PC4; c.alu_src = 1;
                c.reg_write = 1; c.uses_rs1 = 1;
                ill = (f3 != 0);
            end
            7'b1101111: begin
                c.jal = 1; c.result_src = RES_PC4; c.imm_src = IMM_J; c.reg_write = 1;
            end
            7'b0110111: begin
                c.imm_src = IMM_U; c.alu_src = 1; c.alu_control = 5'b01111; c.reg_write = 1;
            end
            7'b0010111: begin
                c.imm_src = IMM_U; c.alu_control = 5'b01110; c.reg_write = 1;
            end
            7'b0001111: ill = 0;
            default: ill = 1;
        endcase
        if (w[1:0] != 2'b11) ill = 1;
        c.illegal = ill;
        if (ill) begin
            c.reg_write = 0; c.mem_load = 0; c.mem_store = 0;
            c.branch = 0; c.jal = 0; c.jalr = 0;
        end
        return c;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [10];
        int          k;
        int          s;
        ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0001111};
        r = $urandom();
        k = $urandom_range(0, 11);
        if (k < 10) begin
            r[6:0] = ops[k];
            s = $urandom_range(0, 3);
            if (s == 0) r[31:25] = 7'h00;
            else if (s == 1) r[31:25] = 7'h20;
            else if (s == 2) r[31:25] = 7'h01;
        end
        return r;
    endfunction

    // Entered just after a rising edge; drives one cycle, checks at the falling edge.
    task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
        logic exp_ready;
        logic pop;
        logic push;
        in_valid  = v;
        in_instr  = w;
        in_pc     = pc_ctr;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        exp_ready = (model_q.size() < DEPTH) || rdy;
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            check("out_ctrl", 64'(out_ctrl), 64'(model_q[0].c));
            check("out_pc", 64'(out_pc), 64'(model_q[0].pc));
            check("out_instr", 64'(out_instr), 64'(model_q[0].w));
        end
        pop  = (model_q.size() != 0) && rdy;
        push = v && exp_ready && !fl;
        if (pop) begin
            $display("[TB] pop  pc=%h instr=%h illegal=%0d flush=%0d",
                     model_q[0].pc, model_q[0].w, model_q[0].c.illegal, fl);
        end
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back('{c: ref_decode(w), pc: pc_ctr, w: w});
        end
        if (push) pc_ctr += 32'd4;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // add x3,x1,x2
        step(1'b1, 32'h002081B3, 1'b1, 1'b0);
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_alu", 64'(out_ctrl.alu_control), 64'h00);
        check("add_regw", 64'(out_ctrl.reg_write), 64'd1);
        check("add_regs", {49'd0, out_ctrl.rd, out_ctrl.rs1, out_ctrl.rs2}, {49'd0, 5'd3, 5'd1, 5'd2});
        check("add_illegal", 64'(out_ctrl.illegal), 64'd0);
        idle(1);

        // srai then lw, back to back
        step(1'b1, 32'h40315093, 1'b1, 1'b0);
        check("srai_alu", 64'(out_ctrl.alu_control), 64'h0D);
        check("srai_imm", 64'(out_ctrl.imm_src), 64'(IMM_SH));
        step(1'b1, 32'h0000A283, 1'b1, 1'b0);
        check("lw_res", 64'(out_ctrl.result_src), 64'(RES_MEM));
        check("lw_load", 64'(out_ctrl.mem_load), 64'd1);
        idle(1);

        // back-pressure: third word waits, then passes when out_ready rises
        step(1'b1, 32'h00500093, 1'b0, 1'b0);
        step(1'b1, 32'h00600113, 1'b0, 1'b0);
        in_valid = 1'b1; in_instr = 32'h00700193; out_ready = 1'b0;
        #1;
        check("full_ready_lo", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check("full_ready_pass", 64'(in_ready), 64'd1);
        step(1'b1, 32'h00700193, 1'b1, 1'b0);
        idle(3);

        // illegal opcodes
        step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        check("ill1", {60'd0, out_ctrl.illegal, out_ctrl.reg_write, out_ctrl.mem_store, out_ctrl.branch}, 64'h8);
        step(1'b1, 32'h0000707F, 1'b1, 1'b0);
        check("ill2", {60'd0, out_ctrl.illegal, out_ctrl.reg_write, out_ctrl.mem_store, out_ctrl.branch}, 64'h8);
        idle(1);

        // flush with a full buffer and a same-cycle input
        step(1'b1, 32'h00100093, 1'b0, 1'b0);
        step(1'b1, 32'h00200113, 1'b0, 1'b0);
        step(1'b1, 32'h00300193, 1'b1, 1'b1);
        check("flush_valid", 64'(out_valid), 64'd0);
        idle(2);

        // mul x3,x1,x2
        step(1'b1, 32'h022081B3, 1'b1, 1'b0);
`ifdef DECODE_MUL_DIV_EN
        check("mul_md", 64'(out_ctrl.md_op), 64'd1);
        check("mul_alu", 64'(out_ctrl.alu_control), 64'h10);
`else
        check("mul_illegal", 64'(out_ctrl.illegal), 64'd1);
        check("mul_md", 64'(out_ctrl.md_op), 64'd0);
`endif
        idle(1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end
        idle(3);

        // asynchronous reset mid-stream
        step(1'b1, 32'h00A00093, 1'b0, 1'b0);
        step(1'b1, 32'h00B00113, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_ctrl", 64'(out_ctrl), 64'd0);
        model_q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 1) != 0, rand_instr(), $urandom_range(0, 1) != 0, 1'b0);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
